// File: rtl/gate_test_pkg.sv
// Shared types and constants for the logic-gate self-test sequencer.
package gate_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int unsigned OP_AND  = 0;
    localparam int unsigned OP_OR   = 1;
    localparam int unsigned OP_XOR  = 2;
    localparam int unsigned OP_NAND = 3;

    // Error counter must hold 2^n_in, one more bit than the vector width.
    function automatic int unsigned err_count_w(input int unsigned n_in);
        return n_in + 1;
    endfunction

endpackage

// File: rtl/gate_selftest_ctrl_if.sv
// Control/status and gate-drive bundle between the sequencer and its controller.
interface gate_selftest_ctrl_if #(
    parameter int unsigned N_IN = 2
);
    localparam int unsigned ERR_W = gate_test_pkg::err_count_w(N_IN);

    logic             start;
    logic             abort;
    logic             Y;
    logic [N_IN-1:0]  stim;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic             fail_valid;
    logic [N_IN-1:0]  fail_vec;

    modport master (
        output start, abort, Y,
        input  stim, busy, done, pass, err_count, fail_valid, fail_vec
    );

    modport slave (
        input  start, abort, Y,
        output stim, busy, done, pass, err_count, fail_valid, fail_vec
    );

endinterface

// File: rtl/gate_ref_model.sv
// Combinational reference: expected reduction-gate output for a given stimulus.
module gate_ref_model
    import gate_test_pkg::*;
#(
    parameter int unsigned N_IN = 2,
    parameter int unsigned OP   = OP_AND
) (
    input  logic [N_IN-1:0] stim,
    output logic            expected_c
);

    always_comb begin
        expected_c = &stim;
        case (OP)
            OP_OR:   expected_c = |stim;
            OP_XOR:  expected_c = ^stim;
            OP_NAND: expected_c = ~&stim;
            default: expected_c = &stim;
        endcase
    end

endmodule

// File: rtl/gate_selftest_ctrl.sv
// Exhaustive self-test sequencer: walks every input vector, waits SETTLE cycles,
// samples the gate output and records error count and first failing vector.
module gate_selftest_ctrl
    import gate_test_pkg::*;
#(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned OP     = OP_AND
) (
    input  logic                clk,
    input  logic                rst_n,
    gate_selftest_ctrl_if.slave bus
);

    localparam int unsigned ERR_W = err_count_w(N_IN);
    localparam int unsigned CNT_W = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(2 ** N_IN);
    localparam logic [N_IN-1:0]  VEC_LAST = '1;

    state_t state, state_nxt;

    logic [N_IN-1:0]  stim_q, stim_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [N_IN-1:0]  fvec_q, fvec_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             fv_q, fv_d;
    logic             expected;
    logic             mismatch;

    gate_ref_model #(
        .N_IN (N_IN),
        .OP   (OP)
    ) u_ref (
        .stim       (stim_q),
        .expected_c (expected)
    );

    assign mismatch = (bus.Y != expected);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.start) state_nxt = ST_APPLY;
            ST_APPLY: begin
                if (bus.abort)            state_nxt = ST_IDLE;
                else if (cnt_q == CNT_LAST) state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (bus.abort)               state_nxt = ST_IDLE;
                else if (stim_q == VEC_LAST) state_nxt = ST_DONE;
                else                         state_nxt = ST_APPLY;
            end
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Next values of every registered output and the settle counter.
    always_comb begin
        stim_d = stim_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        fvec_d = fvec_q;
        busy_d = busy_q;
        done_d = 1'b0;
        pass_d = pass_q;
        fv_d   = fv_q;
        case (state)
            ST_IDLE: begin
                stim_d = '0;
                busy_d = 1'b0;
                if (bus.start) begin
                    busy_d = 1'b1;
                    cnt_d  = '0;
                    err_d  = '0;
                    fv_d   = 1'b0;
                    fvec_d = '0;
                    pass_d = 1'b0;
                end
            end
            ST_APPLY: begin
                if (bus.abort) begin
                    stim_d = '0;
                    busy_d = 1'b0;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (bus.abort) begin
                    stim_d = '0;
                    busy_d = 1'b0;
                    cnt_d  = '0;
                end else begin
                    if (mismatch) begin
                        if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
                        if (!fv_q) begin
                            fv_d   = 1'b1;
                            fvec_d = stim_q;
                        end
                    end
                    if (stim_q == VEC_LAST) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        pass_d = (err_d == '0);
                    end else begin
                        stim_d = stim_q + N_IN'(1);
                    end
                end
            end
            ST_DONE: begin
                stim_d = '0;
            end
            default: begin
                stim_d = '0;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim_q <= '0;
            cnt_q  <= '0;
            err_q  <= '0;
            fvec_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            fv_q   <= 1'b0;
        end else begin
            stim_q <= stim_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            fvec_q <= fvec_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
            fv_q   <= fv_d;
        end
    end

    assign bus.stim       = stim_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.fail_valid = fv_q;
    assign bus.fail_vec   = fvec_q;

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Bench for gate_selftest_ctrl: timeline model of a run checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_gate_selftest_ctrl;

    localparam int unsigned N_IN   = 2;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned OP     = 0;
    localparam int NV  = 1 << N_IN;
    localparam int PER = SETTLE + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   mode  = 0;     // gate attached: 0 AND, 1 stuck-at-1, 2 OR

    int errors    = 0;
    int checks    = 0;
    int done_seen = 0;
    int d0        = 0;
    bit chk_en    = 1'b0;

    gate_selftest_ctrl_if #(.N_IN(N_IN)) bus();

    gate_selftest_ctrl #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE),
        .OP     (OP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic gate_y(input int m, input int k);
        case (m)
            0:       return logic'(k == NV - 1);
            1:       return 1'b1;
            default: return logic'(k != 0);
        endcase
    endfunction

    function automatic bit ref_bit(input int k);
        case (OP)
            0:       return (k == NV - 1);
            1:       return (k != 0);
            2:       return ($countones(k) % 2) == 1;
            default: return (k != NV - 1);
        endcase
    endfunction

    assign bus.Y = gate_y(mode, int'(bus.stim));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: position in the run timeline decides stim/busy/done and when samples happen.
    bit m_run, m_busy, m_done, m_pass, m_fv;
    int m_t, m_stim, m_err, m_fvec;

    task automatic model_step();
        bit was_done;
        int k;
        was_done = m_done;
        m_done   = 1'b0;
        if (was_done) begin
            m_stim = 0;
        end else if (m_run) begin
            m_t++;
            if (bus.abort) begin
                m_run  = 1'b0;
                m_busy = 1'b0;
                m_stim = 0;
            end else if (m_t % PER == 0) begin
                k = m_t / PER - 1;
                if (gate_y(mode, k) != logic'(ref_bit(k))) begin
                    m_err++;
                    if (!m_fv) begin
                        m_fv   = 1'b1;
                        m_fvec = k;
                    end
                end
                if (k == NV - 1) begin
                    m_run  = 1'b0;
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_pass = (m_err == 0);
                end else begin
                    m_stim = k + 1;
                end
            end
        end else if (bus.start) begin
            m_run  = 1'b1;
            m_busy = 1'b1;
            m_t    = 0;
            m_stim = 0;
            m_err  = 0;
            m_fv   = 1'b0;
            m_fvec = 0;
            m_pass = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_run = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_fv = 1'b0;
                m_t = 0; m_stim = 0; m_err = 0; m_fvec = 0;
            end else begin
                model_step();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.done) done_seen++;
            if (chk_en && rst_n) begin
                check("stim",       int'(bus.stim),       m_stim);
                check("busy",       int'(bus.busy),       int'(m_busy));
                check("done",       int'(bus.done),       int'(m_done));
                check("pass",       int'(bus.pass),       int'(m_pass));
                check("err_count",  int'(bus.err_count),  m_err);
                check("fail_valid", int'(bus.fail_valid), int'(m_fv));
                check("fail_vec",   int'(bus.fail_vec),   m_fvec);
            end
        end
    end

    int hist [16];
    int busy_cycles;

    task automatic pulse_start();
        @(negedge clk);
        d0 = done_seen;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        busy_cycles = 0;
        while (!bus.done && lat < 40) begin
            if (lat < 16) hist[lat] = int'(bus.stim);
            if (bus.busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    int lat;

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_stim", int'(bus.stim), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_err",  int'(bus.err_count), 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Correct AND gate
        mode = 0;
        pulse_start();
        wait_done(lat);
        check("and_latency", lat, 12);
        check("and_busy_cycles", busy_cycles, 12);
        for (int j = 0; j < 12; j++) check("and_stim_seq", hist[j], j / 3);
        check("and_pass", int'(bus.pass), 1);
        check("and_err",  int'(bus.err_count), 0);
        check("and_fv",   int'(bus.fail_valid), 0);

        // Stuck-at-1 output
        mode = 1;
        pulse_start();
        wait_done(lat);
        check("sa1_latency", lat, 12);
        check("sa1_err",  int'(bus.err_count), 3);
        check("sa1_fv",   int'(bus.fail_valid), 1);
        check("sa1_fvec", int'(bus.fail_vec), 0);
        check("sa1_pass", int'(bus.pass), 0);

        // OR gate against an AND reference
        mode = 2;
        pulse_start();
        wait_done(lat);
        check("or_err",  int'(bus.err_count), 2);
        check("or_fvec", int'(bus.fail_vec), 1);
        check("or_pass", int'(bus.pass), 0);

        // Abort in the SAMPLE cycle of vector 2
        mode = 1;
        pulse_start();
        repeat (8) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_stim", int'(bus.stim), 0);
        check("abort_err",  int'(bus.err_count), 2);
        repeat (10) @(negedge clk);
        check("abort_no_done", done_seen - d0, 0);
        check("abort_pass", int'(bus.pass), 0);
        check("abort_fvec", int'(bus.fail_vec), 0);

        // Asynchronous reset in APPLY of vector 1
        pulse_start();
        repeat (3) @(negedge clk);
        check("pre_rst_stim", int'(bus.stim), 1);
        check("pre_rst_err",  int'(bus.err_count), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_stim", int'(bus.stim), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_err",  int'(bus.err_count), 0);
        check("arst_fv",   int'(bus.fail_valid), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        mode = 0;
        pulse_start();
        wait_done(lat);
        check("post_rst_latency", lat, 12);
        for (int j = 0; j < 12; j++) check("post_rst_stim_seq", hist[j], j / 3);
        check("post_rst_pass", int'(bus.pass), 1);

        // start held high: next run starts from IDLE after done
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        wait_done(lat);
        check("held_latency", lat, 12);
        @(negedge clk);
        wait_done(lat);
        check("held_rerun_gap", lat + 1, 14);
        bus.start = 1'b0;

        // start pulses while busy are ignored
        pulse_start();
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        check("busy_start_one_done", done_seen - d0, 1);
        check("busy_start_idle", int'(bus.busy), 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
